// File: rtl/psum_accum_buffer.sv
// psum_accum_buffer
//   Sits below the PE array. Each accepted beat carries NUM_COL signed partial
//   sums; they are accumulated (with saturation) into a per-lane buffer across
//   cfg_passes passes of cfg_len beats. After the final pass the buffer is
//   streamed out one beat per handshake, and a one-cycle done pulse follows.
//
//   Ports
//     clk, rstn           clock, asynchronous active-low reset
//     clr                 synchronous abort back to IDLE (sat_flag survives)
//     cfg_start           start pulse; cfg_len / cfg_passes latched when legal
//     in_valid/in_ready   psum beat handshake, in_psum lane c at [c*DATA_WIDTH +: DATA_WIDTH]
//     out_valid/out_ready result handshake, out_data lane c at [c*ACC_WIDTH +: ACC_WIDTH]
//     out_last            final result beat of the job
//     busy, done          job in progress / one-cycle completion pulse
//     sat_flag            sticky: some lane clamped during this job
module psum_accum_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 7,
    parameter int ACC_WIDTH  = 32,
    parameter int DEPTH      = 64,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            clr,
    input  logic                            cfg_start,
    input  logic [ADDR_W:0]                 cfg_len,
    input  logic [7:0]                      cfg_passes,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_COL*DATA_WIDTH-1:0]   in_psum,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_COL*ACC_WIDTH-1:0]    out_data,
    output logic                            out_last,
    output logic                            busy,
    output logic                            done,
    output logic                            sat_flag
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W-1:0]   r_len_m1;
    logic [7:0]          r_pass_cnt;
    logic [7:0]          r_passes_m1;
    logic                r_sat_flag;

    logic                w_cfg_ok;
    logic                w_accept;
    logic                w_out_hs;
    logic                w_wr_last;
    logic                w_rd_last;
    logic                w_pass_last;
    logic [NUM_COL-1:0]  w_lane_sat;

    assign w_cfg_ok    = (cfg_len != '0) && (cfg_len <= (ADDR_W+1)'(DEPTH)) && (cfg_passes != 8'd0);
    // Handshakes decoded straight from the state register so the comb outputs
    // never feed back into themselves.
    assign w_accept    = in_valid && (r_state == ACCUM);
    assign w_out_hs    = out_ready && (r_state == DRAIN);
    assign w_wr_last   = (r_wr_ptr == r_len_m1);
    assign w_rd_last   = (r_rd_ptr == r_len_m1);
    assign w_pass_last = (r_pass_cnt == r_passes_m1);

    // Per-lane storage and read-modify-write datapath. Reads are asynchronous so
    // the accumulate completes in the accepting cycle and the first drain beat
    // is visible in the first DRAIN cycle.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_COL; gi++) begin : g_lane
            logic signed [ACC_WIDTH-1:0]  r_buf [DEPTH];
            logic signed [DATA_WIDTH-1:0] w_lane;
            logic signed [ACC_WIDTH-1:0]  w_ext;
            logic signed [ACC_WIDTH-1:0]  w_old;
            logic signed [ACC_WIDTH:0]    w_sum;
            logic signed [ACC_WIDTH-1:0]  w_wdata;
            logic                         w_ovf;

            assign w_lane = in_psum[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_ext  = ACC_WIDTH'(w_lane);
            assign w_old  = r_buf[r_wr_ptr];
            // One guard bit: overflow shows up as the top two bits disagreeing.
            assign w_sum  = (ACC_WIDTH+1)'(w_old) + (ACC_WIDTH+1)'(w_ext);
            assign w_ovf  = (w_sum[ACC_WIDTH] != w_sum[ACC_WIDTH-1]);

            always_comb begin
                w_wdata = w_ext;
                if (r_pass_cnt != 8'd0) begin
                    if (w_ovf) begin
                        w_wdata = w_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                                   : {1'b0, {(ACC_WIDTH-1){1'b1}}};
                    end else begin
                        w_wdata = w_sum[ACC_WIDTH-1:0];
                    end
                end
            end

            assign w_lane_sat[gi] = (r_pass_cnt != 8'd0) && w_ovf;

            always_ff @(posedge clk) begin
                if (w_accept) begin
                    r_buf[r_wr_ptr] <= w_wdata;
                end
            end

            assign out_data[gi*ACC_WIDTH +: ACC_WIDTH] = out_valid ? r_buf[r_rd_ptr] : '0;
        end
    endgenerate

    // Next state and decoded outputs.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (cfg_start && w_cfg_ok) begin
                    w_state_next = ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (w_accept && w_wr_last && w_pass_last) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = w_rd_last;
                if (w_out_hs && w_rd_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
        if (clr) begin
            w_state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_pass_cnt  <= 8'd0;
            r_len_m1    <= '0;
            r_passes_m1 <= 8'd0;
            r_sat_flag  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (clr) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_pass_cnt <= 8'd0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (cfg_start && w_cfg_ok) begin
                            r_len_m1    <= ADDR_W'(cfg_len - 1'b1);
                            r_passes_m1 <= cfg_passes - 8'd1;
                            r_sat_flag  <= 1'b0;
                            r_wr_ptr    <= '0;
                            r_rd_ptr    <= '0;
                            r_pass_cnt  <= 8'd0;
                        end
                    end
                    ACCUM: begin
                        if (w_accept) begin
                            if (|w_lane_sat) begin
                                r_sat_flag <= 1'b1;
                            end
                            if (w_wr_last) begin
                                r_wr_ptr   <= '0;
                                r_pass_cnt <= r_pass_cnt + 8'd1;
                            end else begin
                                r_wr_ptr <= r_wr_ptr + 1'b1;
                            end
                        end
                    end
                    DRAIN: begin
                        if (w_out_hs) begin
                            r_rd_ptr <= w_rd_last ? '0 : r_rd_ptr + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sat_flag = r_sat_flag;

endmodule
